// File: rtl/triangle_fetch.sv
// triangle_fetch -- data-fetch responder for the triangle pipeline controller.
//
// On an accepted fetch_start the block reads one triangle through a
// single-outstanding-read memory master: nine vertex coordinates
// (v0.x, v0.y, v0.z, v1.x, ... v2.z) from consecutive COORD_WIDTH/8-byte
// slots starting at curr_addr_vertex, then one colour word from
// curr_addr_color. Data is collected in shadow registers and committed to
// the outputs in a single cycle, so the outputs always hold a complete
// triangle. fetch_eoc rises in the same cycle as the new data.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   fetch_start           one-cycle request, accepted only while fetch_eoc=1
//   curr_addr_vertex      byte address of v0.x (sampled on accept)
//   curr_addr_color       byte address of the colour (sampled on accept)
//   fetch_vertexes[i][j]  vertex i, component j (x,y,z)
//   fetch_color           triangle colour
//   fetch_eoc             high = idle and outputs valid
//   mem_read/mem_address  read request, held while mem_waitrequest=1
//   mem_waitrequest       slave stall
//   mem_readdata          read data (low COORD/COLOR_WIDTH bits used)
//   mem_readdatavalid     read data valid
//   fetch_err             (TRIANGLE_FETCH_PROTO_CHECK_EN only) sticky flag for
//                         fetch_start while busy or readdatavalid outside WAIT
//
// Optional feature macro: TRIANGLE_FETCH_PROTO_CHECK_EN
// DATA_WIDTH must be >= max(COORD_WIDTH, COLOR_WIDTH).

module triangle_fetch #(
  parameter int ADDR_WIDTH  = 32,
  parameter int COORD_WIDTH = 16,
  parameter int COLOR_WIDTH = 16,
  parameter int DATA_WIDTH  = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                fetch_start,
  input  logic [ADDR_WIDTH-1:0]               curr_addr_vertex,
  input  logic [ADDR_WIDTH-1:0]               curr_addr_color,
  output logic [2:0][2:0][COORD_WIDTH-1:0]    fetch_vertexes,
  output logic [COLOR_WIDTH-1:0]              fetch_color,
  output logic                                fetch_eoc,
`ifdef TRIANGLE_FETCH_PROTO_CHECK_EN
  output logic                                fetch_err,
`endif
  output logic                                mem_read,
  output logic [ADDR_WIDTH-1:0]               mem_address,
  input  logic                                mem_waitrequest,
  input  logic [DATA_WIDTH-1:0]               mem_readdata,
  input  logic                                mem_readdatavalid
);

  localparam int STRIDE = COORD_WIDTH / 8;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t                          r_state;
  logic [3:0]                      r_k;
  logic [ADDR_WIDTH-1:0]           r_vbase;
  logic [ADDR_WIDTH-1:0]           r_cbase;
  // Shadow slots 0..8 laid out so slot k lands on [k/3][k%3] of the output.
  logic [8:0][COORD_WIDTH-1:0]     r_sh_v;
  logic [COLOR_WIDTH-1:0]          r_sh_c;
  logic [2:0][2:0][COORD_WIDTH-1:0] r_vert;
  logic [COLOR_WIDTH-1:0]          r_color;
  logic                            r_eoc;
  logic                            r_mem_read;
  logic [ADDR_WIDTH-1:0]           r_mem_address;

  logic [3:0]                      w_next_k;
  logic [ADDR_WIDTH-1:0]           w_next_addr;

  assign w_next_k = r_k + 4'd1;
  // Address of the next request; wraps modulo 2^ADDR_WIDTH by construction.
  assign w_next_addr = (w_next_k == 4'd9) ? r_cbase
                     : r_vbase + ADDR_WIDTH'(w_next_k) * ADDR_WIDTH'(STRIDE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_k           <= '0;
      r_vbase       <= '0;
      r_cbase       <= '0;
      r_sh_v        <= '0;
      r_sh_c        <= '0;
      r_vert        <= '0;
      r_color       <= '0;
      r_eoc         <= 1'b1;
      r_mem_read    <= 1'b0;
      r_mem_address <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (fetch_start) begin
            r_vbase       <= curr_addr_vertex;
            r_cbase       <= curr_addr_color;
            r_k           <= '0;
            r_mem_read    <= 1'b1;
            r_mem_address <= curr_addr_vertex;
            r_eoc         <= 1'b0;
            r_state       <= S_REQ;
          end
        end
        S_REQ: begin
          // Address and read stay untouched while the slave stalls.
          if (!mem_waitrequest) begin
            r_mem_read <= 1'b0;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_readdatavalid) begin
            if (r_k == 4'd9) begin
              r_sh_c  <= mem_readdata[COLOR_WIDTH-1:0];
              r_state <= S_DONE;
            end else begin
              r_sh_v[r_k]   <= mem_readdata[COORD_WIDTH-1:0];
              r_k           <= w_next_k;
              r_mem_read    <= 1'b1;
              r_mem_address <= w_next_addr;
              r_state       <= S_REQ;
            end
          end
        end
        S_DONE: begin
          // Atomic commit: all ten fields and fetch_eoc change together.
          r_vert  <= r_sh_v;
          r_color <= r_sh_c;
          r_eoc   <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef TRIANGLE_FETCH_PROTO_CHECK_EN
  logic r_err;
  always_ff @(posedge clk) begin
    if (reset)
      r_err <= 1'b0;
    else if ((fetch_start && !r_eoc) || (mem_readdatavalid && r_state != S_WAIT))
      r_err <= 1'b1;
  end
  assign fetch_err = r_err;
`endif

  assign fetch_vertexes = r_vert;
  assign fetch_color    = r_color;
  assign fetch_eoc      = r_eoc;
  assign mem_read       = r_mem_read;
  assign mem_address    = r_mem_address;

endmodule
